// File: rtl/codec_config_sequencer.sv
// Walks the audio-codec register-init table and hands one 24-bit write at a time to the I2C master,
// retrying NACKed or timed-out transfers before giving up with an error index.
module codec_config_sequencer #(
  parameter logic [7:0] DEV_ADDR    = 8'h34,
  parameter int         NUM_REGS    = 10,
  parameter int         MAX_RETRY   = 3,
  parameter int         TIMEOUT     = 20000,
  parameter int         STARTUP_DLY = 50000
) (
  input  logic        inClock,
  input  logic        rst,
  input  logic        start,
  output logic [23:0] i2c_data,
  output logic        i2c_go,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [3:0]  err_index
);

  localparam int DLY_W = (STARTUP_DLY < 2) ? 1 : $clog2(STARTUP_DLY + 1);
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int RTY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  // TIMEOUT spans go-to-retry-go, so the WAIT window is TIMEOUT-2 cycles (SEND and RETRY take one each).
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 3);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STARTUP_DLY);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [4:0]       IDX_LAST = 5'(NUM_REGS);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DELAY,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_RETRY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [4:0]        idx_q, idx_d;
  logic [23:0]       data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [3:0]        errIdx_q, errIdx_d;

  // The closing "activate" write always sits right after the last table entry.
  function automatic logic [23:0] wordFor(input logic [4:0] idx);
    logic [6:0] regAddr;
    logic [8:0] regData;
    regAddr = 7'd0;
    regData = 9'h000;
    if (idx == IDX_LAST) begin
      regAddr = 7'd9;
      regData = 9'h001;
    end else begin
      case (idx)
        5'd0:    begin regAddr = 7'd15; regData = 9'h000; end
        5'd1:    begin regAddr = 7'd6;  regData = 9'h010; end
        5'd2:    begin regAddr = 7'd0;  regData = 9'h017; end
        5'd3:    begin regAddr = 7'd1;  regData = 9'h017; end
        5'd4:    begin regAddr = 7'd2;  regData = 9'h079; end
        5'd5:    begin regAddr = 7'd3;  regData = 9'h079; end
        5'd6:    begin regAddr = 7'd4;  regData = 9'h012; end
        5'd7:    begin regAddr = 7'd5;  regData = 9'h000; end
        5'd8:    begin regAddr = 7'd7;  regData = 9'h002; end
        5'd9:    begin regAddr = 7'd8;  regData = 9'h000; end
        default: begin regAddr = 7'd0;  regData = 9'h000; end
      endcase
    end
    return {DEV_ADDR, regAddr, regData};
  endfunction

  always_ff @(posedge inClock or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_DELAY;
      dly_q    <= '0;
      tmo_q    <= '0;
      retry_q  <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      errIdx_q <= '0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      tmo_q    <= tmo_d;
      retry_q  <= retry_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      errIdx_q <= errIdx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    tmo_d    = tmo_q;
    retry_d  = retry_q;
    idx_d    = idx_q;
    data_d   = data_q;
    done_d   = done_q;
    error_d  = error_q;
    errIdx_d = errIdx_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_DELAY;
          dly_d   = '0;
          idx_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      ST_DELAY: begin
        if (dly_q == DLY_LAST) state_d = ST_LOAD;
        else                   dly_d   = dly_q + 1'b1;
      end
      ST_LOAD: begin
        data_d  = wordFor(idx_q);
        retry_d = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      // A done pulse on the final timeout cycle still wins over the timeout.
      ST_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (i2c_done && i2c_ack)               state_d = ST_NEXT;
        else if (i2c_done || tmo_q == TMO_LAST) state_d = ST_RETRY;
      end
      ST_RETRY: begin
        if (retry_q < RTY_MAX) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_SEND;
        end else begin
          errIdx_d = idx_q[3:0];
          error_d  = 1'b1;
          state_d  = ST_ERROR;
        end
      end
      ST_NEXT: begin
        if (idx_q == IDX_LAST) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});
  end

  assign i2c_go    = (state_q == ST_SEND);
  assign i2c_data  = data_q;
  assign busy      = busy_q;
  assign cfg_done  = done_q;
  assign cfg_error = error_q;
  assign err_index = errIdx_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Randomized bench for codec_config_sequencer: plays the I2C master and predicts every go pulse,
// word and final flag from the init-table rules.
module tb_codec_config_sequencer;

  localparam int S  = 10;
  localparam int T  = 100;
  localparam int MR = 3;
  localparam int N  = 10;

  localparam int ACK  = 0;
  localparam int NACK = 1;
  localparam int NONE = 2;

  logic        inClock = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_ack = 1'b0;
  logic [23:0] i2c_data;
  logic        i2c_go;
  logic        busy;
  logic        cfg_done;
  logic        cfg_error;
  logic [3:0]  err_index;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  int regTab[11]  = '{15, 6, 0, 1, 2, 3, 4, 5, 7, 8, 9};
  int dataTab[11] = '{'h000, 'h010, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h002, 'h000, 'h001};

  codec_config_sequencer #(
    .DEV_ADDR   (8'h34),
    .NUM_REGS   (N),
    .MAX_RETRY  (MR),
    .TIMEOUT    (T),
    .STARTUP_DLY(S)
  ) dut (
    .inClock  (inClock),
    .rst      (rst),
    .start    (start),
    .i2c_data (i2c_data),
    .i2c_go   (i2c_go),
    .i2c_done (i2c_done),
    .i2c_ack  (i2c_ack),
    .busy     (busy),
    .cfg_done (cfg_done),
    .cfg_error(cfg_error),
    .err_index(err_index)
  );

  always #5 inClock = ~inClock;

  always @(posedge inClock) cyc++;

  // Abort rather than hang if the design stalls somewhere unexpected.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] expWord(input int idx);
    logic [6:0] r;
    logic [8:0] d;
    r = 7'(regTab[idx]);
    d = 9'(dataTab[idx]);
    return {8'h34, r, d};
  endfunction

  // One-cycle pulses are raised after a tick and dropped by the next one.
  task automatic tick();
    @(negedge inClock);
    i2c_done = 1'b0;
    i2c_ack  = 1'($urandom_range(0, 1));
    start    = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Go"},     i2c_go,    0);
    checkOutput({tag, "Data"},   i2c_data,  0);
    checkOutput({tag, "Busy"},   busy,      0);
    checkOutput({tag, "Done"},   cfg_done,  0);
    checkOutput({tag, "Err"},    cfg_error, 0);
    checkOutput({tag, "ErrIdx"}, err_index, 0);
  endtask

  task automatic applyReset(output int relCyc);
    rst = 1'b0;
    tick();
    tick();
    checkResetValues("rst");
    rst = 1'b1;
    relCyc = cyc;
  endtask

  task automatic pickResponse(input int mode, input int idx, input int attempt,
                              output int kind, output int d);
    int r;
    kind = ACK;
    d    = $urandom_range(1, 20);
    case (mode)
      1: if (idx == 3 && attempt == 0) kind = NACK;
      2: if (idx == 2) kind = NACK;
      3: if (idx == 0) kind = NONE;
      4: begin
        d = T - 2;
        if (idx == 4 && attempt == 0) d = T - 1;
      end
      5: begin
        r = $urandom_range(0, 7);
        if (r == 0)      kind = NACK;
        else if (r == 1) kind = NONE;
        if ($urandom_range(0, 3) == 0) d = $urandom_range(1, T - 1);
      end
      default: ;
    endcase
  endtask

  // Plays the I2C master for one full run and checks every go against the predicted cycle and word.
  task automatic applyStimulus(input int mode, input int firstGo);
    int  idx, attempt, expectGo, endCyc, kind, d, eff, goCyc, expErrIdx, strays;
    bit  finished, found, expDone, expErr;
    idx = 0; attempt = 0; expectGo = firstGo; endCyc = 0; expErrIdx = 0;
    finished = 0; expDone = 0; expErr = 0;
    while (!finished) begin
      found = 0;
      while (!found && cyc <= expectGo + 5) begin
        if (i2c_go === 1'b1) found = 1;
        else tick();
      end
      checkOutput($sformatf("goSeen%0d", idx), 32'(found), 1);
      if (!found) return;
      goCyc = cyc;
      checkOutput($sformatf("goTime%0d", idx), goCyc, expectGo);
      checkOutput($sformatf("word%0d", idx), i2c_data, expWord(idx));
      checkOutput("busyGo", busy, 1);
      tick();
      checkOutput("goPulse", i2c_go, 0);
      if (mode == 6 && idx == 5) begin
        tick();
        #1 rst = 1'b0;
        #1;
        checkResetValues("midRst");
        return;
      end
      pickResponse(mode, idx, attempt, kind, d);
      if (kind != NONE) begin
        for (int k = 1; k < d; k++) begin
          tick();
          if (mode == 5 && k == d / 2) start = 1'b1;
        end
        i2c_done = 1'b1;
        i2c_ack  = (kind == ACK);
        checkOutput("hold", i2c_data, expWord(idx));
        tick();
      end
      eff = ((kind != NONE) && d <= T - 2) ? d : T - 2;
      if (kind == ACK && d <= T - 2) begin
        if (idx == N) begin
          expDone = 1; endCyc = goCyc + d; finished = 1;
        end else begin
          idx++; attempt = 0; expectGo = goCyc + d + 3;
        end
      end else if (attempt < MR) begin
        attempt++; expectGo = goCyc + eff + 2;
      end else begin
        expErr = 1; expErrIdx = idx; endCyc = goCyc + eff; finished = 1;
      end
    end
    while (cyc < endCyc + 2) tick();
    checkOutput("endBusy", busy, 0);
    checkOutput("endDone", cfg_done, 32'(expDone));
    checkOutput("endError", cfg_error, 32'(expErr));
    if (expErr) checkOutput("endErrIdx", err_index, expErrIdx);
    strays = 0;
    for (int k = 0; k < T + 50; k++) begin
      if (i2c_go === 1'b1) strays++;
      tick();
      if (k == 10) begin
        i2c_done = 1'b1;
        i2c_ack  = 1'b0;
      end
    end
    checkOutput("strayGo", strays, 0);
    checkOutput("heldDone", cfg_done, 32'(expDone));
    checkOutput("heldError", cfg_error, 32'(expErr));
  endtask

  initial begin
    int rel;
    #1 rst = 1'b0;
    @(negedge inClock);
    $display("[TB] reset and clean run");
    applyReset(rel);
    tick();
    i2c_done = 1'b1;
    i2c_ack  = 1'b1;
    applyStimulus(0, rel + S + 2);

    for (int m = 1; m <= 4; m++) begin
      $display("[TB] start-triggered run, mode %0d", m);
      tick();
      start = 1'b1;
      rel = cyc;
      applyStimulus(m, rel + S + 3);
    end

    $display("[TB] reset during WAIT, start during DELAY");
    tick();
    start = 1'b1;
    rel = cyc;
    applyStimulus(6, rel + S + 3);
    tick();
    applyReset(rel);
    tick();
    tick();
    start = 1'b1;
    applyStimulus(0, rel + S + 2);

    for (int r = 0; r < 4; r++) begin
      $display("[TB] random run %0d", r);
      tick();
      start = 1'b1;
      rel = cyc;
      applyStimulus(5, rel + S + 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
